// File: rtl/d_cache_pkg.sv
// Widths, FSM states and address field helpers shared by the direct-mapped data cache.
// Pure declarations; no timing or backpressure of its own.
package d_cache_pkg;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 29;
  localparam int NUM_LINES = 8;
  localparam int BLK_WORDS = 4;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int OFF_W     = $clog2(BLK_WORDS);
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W     = DATA_W * BLK_WORDS;
  localparam int BADDR_W   = ADDR_W - OFF_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [OFF_W-1:0]   off_t;
  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [BLK_W-1:0]   blk_t;
  typedef logic [BADDR_W-1:0] baddr_t;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic idx_t addr_idx(input addr_t a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic off_t addr_off(input addr_t a);
    return a[OFF_W-1:0];
  endfunction

  function automatic baddr_t blk_addr(input tag_t t, input idx_t i);
    return {t, i};
  endfunction

  // Word 0 of a block sits in the least significant bits.
  function automatic word_t blk_word(input blk_t b, input off_t o);
    return b[o*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/d_cache_if.sv
// Core-side and memory-side signals of the data cache; slave = cache, master = core + memory.
// Core holds requests while proc_stall is high; memory completes a block request with mem_ready.
interface d_cache_if;
  import d_cache_pkg::*;

  logic   proc_read;
  logic   proc_write;
  addr_t  proc_addr;
  word_t  proc_wdata;
  word_t  proc_rdata;
  logic   proc_stall;

  logic   mem_read;
  logic   mem_write;
  baddr_t mem_addr;
  blk_t   mem_wdata;
  blk_t   mem_rdata;
  logic   mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/d_cache_array.sv
// Tag/valid/dirty/data storage for the cache: combinational read of one line, updates at the edge.
// Latency: read 0 cycles, writes visible next cycle; no backpressure, all ports always accepted.
module d_cache_array
  import d_cache_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  idx_t  idx,
  input  logic  wr_vld,
  input  off_t  wr_off,
  input  word_t wr_dat,
  input  logic  fill_vld,
  input  tag_t  fill_tag,
  input  blk_t  fill_dat,
  input  logic  clr_vld,
  output logic  line_valid,
  output logic  line_dirty,
  output tag_t  line_tag,
  output blk_t  line_dat
);
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  tag_t                 tag_q  [NUM_LINES];
  tag_t                 tag_d  [NUM_LINES];
  blk_t                 data_q [NUM_LINES];
  blk_t                 data_d [NUM_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_vld) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
      data_d[idx]  = fill_dat;
    end
    if (clr_vld) begin
      dirty_d[idx] = 1'b0;
    end
    if (wr_vld) begin
      data_d[idx][wr_off*DATA_W +: DATA_W] = wr_dat;
      dirty_d[idx]                         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign line_valid = valid_q[idx];
  assign line_dirty = dirty_q[idx];
  assign line_tag   = tag_q[idx];
  assign line_dat   = data_q[idx];
endmodule

// File: rtl/d_cache.sv
// Direct-mapped write-back write-allocate data cache; hit answers in the same cycle, no stall.
// Miss stalls L+1 (clean) or 2L+1 (dirty) cycles while whole blocks move under mem_ready.
module d_cache
  import d_cache_pkg::*;
(
  input logic      clk,
  input logic      rst,
  d_cache_if.slave bus
);
  state_e state_q, state_d;
  baddr_t mem_addr_q, mem_addr_d;
  blk_t   mem_wdata_q, mem_wdata_d;

  logic   req, hit;
  logic   proc_stall, mem_read, mem_write;
  logic   wr_vld, fill_vld, clr_vld;
  logic   line_valid, line_dirty;
  tag_t   line_tag, req_tag;
  idx_t   req_idx;
  off_t   req_off;
  blk_t   line_dat;

  assign req_tag = addr_tag(bus.proc_addr);
  assign req_idx = addr_idx(bus.proc_addr);
  assign req_off = addr_off(bus.proc_addr);
  assign req     = bus.proc_read | bus.proc_write;
  assign hit     = req && line_valid && (line_tag == req_tag);

  d_cache_array u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (req_idx),
    .wr_vld     (wr_vld),
    .wr_off     (req_off),
    .wr_dat     (bus.proc_wdata),
    .fill_vld   (fill_vld),
    .fill_tag   (req_tag),
    .fill_dat   (bus.mem_rdata),
    .clr_vld    (clr_vld),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_dat   (line_dat)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    proc_stall  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    wr_vld      = 1'b0;
    fill_vld    = 1'b0;
    clr_vld     = 1'b0;
    case (state_q)
      COMPARE: begin
        if (req) begin
          if (hit) begin
            // A store with proc_read also high is still a store.
            wr_vld = bus.proc_write;
          end else begin
            proc_stall = 1'b1;
            if (line_valid && line_dirty) begin
              state_d     = WRITEBACK;
              mem_addr_d  = blk_addr(line_tag, req_idx);
              mem_wdata_d = line_dat;
            end else begin
              state_d    = ALLOCATE;
              mem_addr_d = blk_addr(req_tag, req_idx);
            end
          end
        end
      end
      WRITEBACK: begin
        mem_write  = 1'b1;
        proc_stall = 1'b1;
        if (bus.mem_ready) begin
          clr_vld    = 1'b1;
          mem_addr_d = blk_addr(req_tag, req_idx);
          state_d    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read   = 1'b1;
        proc_stall = 1'b1;
        // After the fill the request replays in COMPARE as a hit; a store merges there.
        if (bus.mem_ready) begin
          fill_vld = 1'b1;
          state_d  = COMPARE;
        end
      end
      default: begin
        state_d = COMPARE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMPARE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.proc_rdata = blk_word(line_dat, req_off);
  assign bus.proc_stall = proc_stall;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_d_cache.sv
// Bench for d_cache: random core traffic against a line-level cache model and a latency-programmable memory.
module tb_d_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  d_cache_if bus();

  d_cache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit            wr;
    logic [26:0]   addr;
    logic [255:0]  dat;
  } mexp_t;

  typedef struct {
    bit            rd;
    logic [63:0]   dat;
    int            stalls;
  } pexp_t;

  int     errors = 0;
  int     checks = 0;
  int     lat = 1;
  bit     ready_hold = 1'b0;
  bit     stuck = 1'b0;
  mexp_t  mem_q[$];
  pexp_t  rsp_q[$];

  // Reference: main-memory contents plus which block each of the 8 lines holds.
  logic [63:0]  mref [logic [28:0]];
  logic [255:0] mblk [logic [26:0]];
  bit           cvalid [8];
  bit           cdirty [8];
  logic [23:0]  ctag   [8];
  logic [63:0]  cdata  [8][4];

  function automatic logic [63:0] init_word(input logic [28:0] a);
    return {6'h2A, a, ~a};
  endfunction

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    if (mref.exists(a)) return mref[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] mem_block(input logic [26:0] b);
    logic [255:0] r;
    if (mblk.exists(b)) return mblk[b];
    for (int w = 0; w < 4; w++) r[w*64 +: 64] = init_word({b, 2'(w)});
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic [28:0] a, input bit is_wr, input logic [63:0] wd, input int l);
    logic [23:0]  t;
    int           i;
    int           o;
    int           st;
    logic [255:0] b;
    mexp_t        m;
    pexp_t        p;
    t  = a[28:5];
    i  = int'(a / 4) % 8;
    o  = int'(a % 4);
    st = 0;
    if (!(cvalid[i] && ctag[i] == t)) begin
      st = l + 1;
      if (cvalid[i] && cdirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          b[w*64 +: 64] = cdata[i][w];
          mref[{ctag[i], 3'(i), 2'(w)}] = cdata[i][w];
        end
        m.wr = 1'b1; m.addr = {ctag[i], 3'(i)}; m.dat = b;
        mem_q.push_back(m);
        st = st + l;
      end
      m.wr = 1'b0; m.addr = {t, 3'(i)}; m.dat = '0;
      mem_q.push_back(m);
      for (int w = 0; w < 4; w++) cdata[i][w] = mem_word({t, 3'(i), 2'(w)});
      cvalid[i] = 1'b1;
      cdirty[i] = 1'b0;
      ctag[i]   = t;
    end
    if (is_wr) begin
      cdata[i][o] = wd;
      cdirty[i]   = 1'b1;
    end
    p.rd = !is_wr; p.dat = cdata[i][o]; p.stalls = st;
    rsp_q.push_back(p);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; leaves the bench just after the edge that accepts the op.
  task automatic run_op(input logic [28:0] a, input bit wr, input bit rd, input logic [63:0] wd, input int l);
    int n;
    lat = l;
    model_access(a, wr, wd, l);
    bus.proc_addr  = a;
    bus.proc_write = wr;
    bus.proc_read  = rd;
    bus.proc_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.proc_stall && n < 4*l + 8);
    if (bus.proc_stall) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: addr %0h still stalled after %0d cycles, expected release", a, n);
      stuck = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  task automatic reset_mid(input logic [28:0] a);
    mexp_t m;
    lat = 50;
    m.wr = 1'b0; m.addr = a[28:2]; m.dat = '0;
    mem_q.push_back(m);
    bus.proc_addr  = a;
    bus.proc_read  = 1'b1;
    bus.proc_write = 1'b0;
    idle(3);
    chk("mid_alloc_mem_read", bus.mem_read, 1'b1);
    rst = 1'b1;
    bus.proc_read = 1'b0;
    idle(1);
    rst = 1'b0;
    chk("post_rst_mem_read", bus.mem_read, 1'b0);
    chk("post_rst_mem_write", bus.mem_write, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cvalid[i] = 1'b0;
      cdirty[i] = 1'b0;
    end
  endtask

  initial begin : memory
    int    cnt;
    mexp_t m;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = ready_hold;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        if (cnt == 0) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: rd=%0b wr=%0b addr=%0h, expected no memory request", bus.mem_read, bus.mem_write, bus.mem_addr);
          end else begin
            m = mem_q.pop_front();
            chk("mem_write", bus.mem_write, m.wr);
            chk("mem_read", bus.mem_read, !m.wr);
            chk("mem_addr", bus.mem_addr, m.addr);
            if (m.wr) chk("mem_wdata", bus.mem_wdata, m.dat);
          end
        end
        cnt++;
        if (cnt >= lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_write) mblk[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_block(bus.mem_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    int    scnt;
    pexp_t p;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0;
      end else if (bus.proc_read || bus.proc_write) begin
        if (bus.proc_stall) begin
          scnt++;
        end else begin
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: addr %0h completed, expected no pending op", bus.proc_addr);
          end else begin
            p = rsp_q.pop_front();
            chk("stall_cycles", scnt, p.stalls);
            if (p.rd) chk("proc_rdata", bus.proc_rdata, p.dat);
          end
          scnt = 0;
        end
      end else begin
        chk("idle_stall", bus.proc_stall, 1'b0);
        chk("idle_mem_req", {bus.mem_read, bus.mem_write}, 2'b00);
      end
    end
  end

  initial begin : driver
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", bus.proc_stall, 1'b0);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    idle(1);

    run_op(29'h10, 1'b0, 1'b1, 64'h0, 4);                     // cold read miss, L=4
    run_op(29'h13, 1'b0, 1'b1, 64'h0, 4);                     // hit, word 3
    run_op(29'h11, 1'b1, 1'b0, 64'hDEADBEEF, 3);              // write hit makes line dirty
    run_op(29'h31, 1'b0, 1'b1, 64'h0, 3);                     // conflict: writeback then allocate
    run_op(29'h45, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 2);   // write miss on clean line
    run_op(29'h46, 1'b0, 1'b1, 64'h0, 2);
    run_op(29'h65, 1'b0, 1'b1, 64'h0, 2);                     // evicts the stored word
    run_op(29'h45, 1'b0, 1'b1, 64'h0, 1);                     // reads back written-back data
    run_op(29'h44, 1'b1, 1'b1, 64'hA5A5_0000_FFFF_1234, 1);   // read+write counts as write
    run_op(29'h44, 1'b0, 1'b1, 64'h0, 1);

    reset_mid(29'h80);
    run_op(29'h80, 1'b0, 1'b1, 64'h0, 3);                     // misses again after reset

    ready_hold = 1'b1;
    idle(6);
    ready_hold = 1'b0;
    idle(1);

    for (int k = 0; k < 250 && !stuck; k++) begin
      logic [28:0] a;
      int          kind;
      a    = 29'($urandom_range(0, 127));
      kind = $urandom_range(0, 3);
      run_op(a, kind >= 2, kind != 2, {$urandom, $urandom}, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
